freq_gate_counter: RTL and testbench

- Measurement stage directly downstream of the input multiplexer.
- Takes the selected asynchronous chip output (mux out_wave) and counts its rising edges over a fixed gate window of reference-clock cycles.
- Latches the result and presents it to the readout/host interface with a valid/ack handshake.
- Count is in edges per gate, so frequency = count × f_Clock / GATE_CYCLES.

---
 rtl/freq_gate_counter.sv | 120 ++++++++++++
 tb/tb_freq_gate_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_counter.sv
// Counts rising edges of an asynchronous input over a fixed gate of GATE_CYCLES reference clocks.
// Result latency: 1 ARM cycle + GATE_CYCLES gate cycles. The result is held until count_ack.
module freq_gate_counter #(
    parameter int COUNT_WIDTH = 32,
    parameter int GATE_CYCLES = 50000000
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   in_wave,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   count_ack,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   count_valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, GATE, HOLD} state_t;

    state_t                 state;
    logic                   s1, s2, s3;
    logic                   edge_det;
    logic [TW-1:0]          gate_timer;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic                   sat;
    logic                   cnt_at_max;

    // s1/s2 resolve metastability; s3 only delays s2 so that a rising edge can be detected.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_wave;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det   = s2 & ~s3;
    assign cnt_at_max = (edge_cnt == CNT_MAX);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            gate_timer  <= '0;
            edge_cnt    <= '0;
            sat         <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && enable) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    gate_timer <= '0;
                    edge_cnt   <= '0;
                    sat        <= 1'b0;
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= GATE;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gate_timer <= gate_timer + TW'(1);
                        if (edge_det) begin
                            if (cnt_at_max) begin
                                sat <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + COUNT_WIDTH'(1);
                            end
                        end
                        // The last gate cycle's own edge is folded into the latched result.
                        if (gate_timer == LAST_TICK) begin
                            count       <= (edge_det && !cnt_at_max) ? edge_cnt + COUNT_WIDTH'(1) : edge_cnt;
                            overflow    <= sat | (edge_det & cnt_at_max);
                            count_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (count_ack) begin
                        count_valid <= 1'b0;
                        if (start && enable) begin
                            state <= ARM;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: a main instance with GATE_CYCLES=100 and COUNT_WIDTH=8.
// A second instance with COUNT_WIDTH=4 shares the controls and is driven by a faster wave.
module tb_freq_gate_counter;

    logic       clk;
    logic       nReset;
    logic       in_wave;
    logic       in_fast;
    logic       wave_on;
    logic       enable;
    logic       start;
    logic       count_ack;
    logic [7:0] count;
    logic       count_valid;
    logic       overflow;
    logic       busy;
    logic [3:0] count2;
    logic       count_valid2;
    logic       overflow2;
    logic       busy2;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int bcnt;

    freq_gate_counter #(.COUNT_WIDTH(8), .GATE_CYCLES(100)) dut (
        .Clock(clk), .nReset(nReset), .in_wave(in_wave), .enable(enable),
        .start(start), .count_ack(count_ack), .count(count),
        .count_valid(count_valid), .overflow(overflow), .busy(busy)
    );

    freq_gate_counter #(.COUNT_WIDTH(4), .GATE_CYCLES(100)) dut_sat (
        .Clock(clk), .nReset(nReset), .in_wave(in_fast), .enable(enable),
        .start(start), .count_ack(count_ack), .count(count2),
        .count_valid(count_valid2), .overflow(overflow2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 100 ns period, edges offset from the clock edges; forced low while wave_on is 0.
    initial begin
        in_wave = 1'b0;
        #3;
        forever begin
            #50;
            in_wave = wave_on ? ~in_wave : 1'b0;
        end
    end

    // 40 ns period: 25 edges per 100-cycle gate.
    initial begin
        in_fast = 1'b0;
        #1;
        forever begin
            #20;
            in_fast = ~in_fast;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for count_valid; lat = cycles from ARM entry to valid, -1 on timeout.
    task automatic wait_valid(output int lat_o, output int bcnt_o);
        int cyc;
        cyc    = 0;
        bcnt_o = 0;
        lat_o  = -1;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (busy) bcnt_o++;
            if (count_valid) begin
                lat_o = cyc - 1;
                break;
            end
        end
    endtask

    task automatic run_gate(output int lat_o, output int bcnt_o);
        @(negedge clk);
        start  = 1'b1;
        enable = 1'b1;
        wait_valid(lat_o, bcnt_o);
    endtask

    task automatic ack_only();
        @(negedge clk);
        count_ack = 1'b1;
        @(negedge clk);
        count_ack = 1'b0;
        chk("ack_valid_clr", int'(count_valid), 0);
        chk("ack_busy", int'(busy), 0);
    endtask

    initial begin
        nReset    = 1'b0;
        enable    = 1'b0;
        start     = 1'b0;
        count_ack = 1'b0;
        wave_on   = 1'b1;
        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(count_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal count at four different start phases.
        for (int ph = 0; ph < 4; ph++) begin
            repeat (ph * 3 + 1) @(negedge clk);
            run_gate(lat, bcnt);
            chk("nom_latency", lat, 101);
            chk("nom_busy_cycles", bcnt, 101);
            chk("nom_count", int'(count), 10);
            chk("nom_ovf", int'(overflow), 0);
            if (ph == 0) begin
                chk("sat_count", int'(count2), 15);
                chk("sat_ovf", int'(overflow2), 1);
                chk("sat_valid", int'(count_valid2), 1);
            end
            ack_only();
        end

        // No input activity.
        wave_on = 1'b0;
        repeat (12) @(negedge clk);
        run_gate(lat, bcnt);
        chk("zero_latency", lat, 101);
        chk("zero_count", int'(count), 0);
        chk("zero_ovf", int'(overflow), 0);
        chk("zero_valid", int'(count_valid), 1);
        ack_only();
        wave_on = 1'b1;
        repeat (12) @(negedge clk);

        // Abort at gate cycle 50.
        run_gate(lat, bcnt);
        chk("pre_abort_count", int'(count), 10);
        ack_only();
        @(negedge clk);
        start  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_arm_busy", int'(busy), 1);
        repeat (51) @(negedge clk);
        chk("abort_gate_busy", int'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(count_valid), 0);
        chk("abort_count", int'(count), 10);
        repeat (5) @(negedge clk);
        chk("abort_valid_late", int'(count_valid), 0);
        chk("abort_count_late", int'(count), 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("noen_busy", int'(busy), 0);
        @(negedge clk);
        chk("noen_busy2", int'(busy), 0);

        // Handshake: hold without ack, then back-to-back, then ack alone.
        run_gate(lat, bcnt);
        chk("hs_latency", lat, 101);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hs_hold_valid", int'(count_valid), 1);
            chk("hs_hold_busy", int'(busy), 0);
            chk("hs_hold_count", int'(count), 10);
            start = (i % 4 == 1);
        end
        start = 1'b0;
        @(negedge clk);
        count_ack = 1'b1;
        start     = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        count_ack = 1'b0;
        start     = 1'b0;
        chk("b2b_valid", int'(count_valid), 0);
        chk("b2b_busy", int'(busy), 1);
        wait_valid(lat, bcnt);
        chk("b2b_latency", lat, 100);
        chk("b2b_count", int'(count), 10);
        ack_only();
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Asynchronous reset at gate cycle 40.
        @(negedge clk);
        start  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (41) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_valid", int'(count_valid), 0);
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count2", int'(count2), 0);
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        run_gate(lat, bcnt);
        chk("post_rst_latency", lat, 101);
        chk("post_rst_count", int'(count), 10);
        chk("post_rst_ovf", int'(overflow), 0);
        ack_only();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
